program_counter_unit: RTL and testbench

Architectural program-counter register for the pipelined RV32 core's fetch stage. Each rising clock edge it loads the next-PC value chosen upstream (sequential, branch or jump target) and presents it to instruction memory. It also provides derived status the fetch and hazard logic consume: the sequential successor, a misalignment flag, the previous PC and a control-flow-discontinuity flag.

---
 rtl/program_counter_unit.sv | 46 ++++
 tb/tb_program_counter_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter: loads the next PC every cycle and
// derives the sequential successor, previous PC and jump status.
module program_counter_unit #(
   parameter int unsigned         WIDTH       = 32,
   parameter logic [WIDTH-1:0]    RESET_VALUE = 32'h0000_0000,
   parameter int unsigned         STEP        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc_in,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_seq,
   output logic [WIDTH-1:0] pc_prev,
   output logic             pc_misaligned,
   output logic             pc_jump
);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] prev_q;
   logic             jump_q;
   logic [WIDTH-1:0] seq_w;

   // Carry out of the top bit is dropped so the successor wraps.
   assign seq_w = pc_q + STEP_W;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= RESET_VALUE;
         prev_q <= RESET_VALUE;
         jump_q <= 1'b0;
      end else begin
         pc_q   <= pc_in;
         prev_q <= pc_q;
         jump_q <= (pc_in != seq_w);
      end
   end

   assign pc_out        = pc_q;
   assign pc_seq        = seq_w;
   assign pc_prev       = prev_q;
   assign pc_jump       = jump_q;
   assign pc_misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed plus randomized bench for program_counter_unit,
// checked against an arithmetic reference model.
module tb_program_counter_unit;

   logic        clk;
   logic        rst;
   logic        clk_en;
   logic [31:0] pc_in;
   logic [31:0] pc_out;
   logic [31:0] pc_seq;
   logic [31:0] pc_prev;
   logic        pc_misaligned;
   logic        pc_jump;

   int total;
   int bad;

   // reference state: plain integers, wrap done with modulo 2^32
   longint m_pc;
   longint m_prev;
   bit     m_jump;

   program_counter_unit dut (
      .clk           (clk),
      .rst           (rst),
      .pc_in         (pc_in),
      .pc_out        (pc_out),
      .pc_seq        (pc_seq),
      .pc_prev       (pc_prev),
      .pc_misaligned (pc_misaligned),
      .pc_jump       (pc_jump)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic longint wrap(input longint a);
      return a % (64'd1 << 32);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc_out"}, pc_out, 32'(m_pc));
      chk({tag, ".pc_seq"}, pc_seq, 32'(wrap(m_pc + 4)));
      chk({tag, ".pc_prev"}, pc_prev, 32'(m_prev));
      chk({tag, ".pc_jump"}, {31'd0, pc_jump}, {31'd0, m_jump});
      chk({tag, ".misal"}, {31'd0, pc_misaligned},
          {31'd0, (m_pc % 4) != 0});
   endtask

   task automatic model_reset();
      m_pc   = 0;
      m_prev = 0;
      m_jump = 0;
   endtask

   task automatic step(input longint v, input string tag);
      pc_in = 32'(v);
      @(posedge clk);
      m_jump = (v != wrap(m_pc + 4));
      m_prev = m_pc;
      m_pc   = v;
      #1;
      chk_all(tag);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #1 rst = 1'b0;
      model_reset();
      #1 chk_all(tag);
      #1 rst = 1'b1;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      clk    = 1'b0;
      clk_en = 1'b0;
      rst    = 1'b0;
      pc_in  = 32'h1234_5678;
      model_reset();

      // reset with clock idle
      #3;
      chk_all("reset");
      chk("reset.seq4", pc_seq, 32'd4);
      #4 rst = 1'b1;
      #3 clk_en = 1'b1;

      // sequential run
      for (int i = 1; i <= 10; i++) begin
         step(wrap(m_pc + 4), "seq");
         chk("seq.abs", pc_out, 32'(4 * i));
      end

      // mid-run reset, then reload 4
      pulse_reset("midrst");
      chk("midrst.zero", pc_out, 32'd0);
      step(4, "after_rst");
      chk("after_rst.jump0", {31'd0, pc_jump}, 32'd0);

      // reset held across a clock edge overrides it
      @(negedge clk);
      rst   = 1'b0;
      pc_in = 32'hDEAD_BEE0;
      model_reset();
      @(posedge clk);
      #1 chk_all("rst_over_edge");
      @(negedge clk);
      #1 rst = 1'b1;

      // jump and misalignment
      step(64'h1234_5678, "jump1");
      chk("jump1.seq", pc_seq, 32'h1234_567C);
      step(64'h9ABC_DEFF, "jump2");
      chk("jump2.prev", pc_prev, 32'h1234_5678);
      chk("jump2.misal", {31'd0, pc_misaligned}, 32'd1);

      // wrap-around
      step(64'hFFFF_FFFC, "wrap1");
      chk("wrap1.seq", pc_seq, 32'h0000_0000);
      step(0, "wrap2");
      chk("wrap2.jump0", {31'd0, pc_jump}, 32'd0);

      // hold (self-load)
      for (int i = 0; i < 3; i++) begin
         step(m_pc, "hold");
         chk("hold.prev_eq", pc_prev, pc_out);
      end

      // randomized mix
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: step(wrap(m_pc + 4), "rnd_seq");
            4, 5:       step(longint'($urandom()), "rnd_any");
            6:          step({$urandom() & 32'hFFFF_FFFC}, "rnd_alg");
            7:          step(m_pc, "rnd_hold");
            8:          step(64'hFFFF_FFFC, "rnd_top");
            default:    pulse_reset("rnd_rst");
         endcase
      end

      clk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
